// File: rtl/jerk_profile_gen_mc_if.sv
// Segment command stream into the multi-axis jerk profile generator.
// Carries one segment per valid/ready handshake: a duration in acc_steps and one jerk per axis.
// master = planner side (drives valid/len/j), slave = generator side (drives ready).
interface jerk_profile_gen_mc_if #(
    parameter int N_AXES = 4,
    parameter int V_W    = 32,
    parameter int LEN_W  = 24
);
    logic                    seg_valid;
    logic                    seg_ready;
    logic [LEN_W-1:0]        seg_len;
    logic [N_AXES*V_W-1:0]   seg_j;

    modport master (output seg_valid, output seg_len, output seg_j, input  seg_ready);
    modport slave  (input  seg_valid, input  seg_len, input  seg_j, output seg_ready);
endinterface

// File: rtl/jerk_profile_gen_mc.sv
// Multi-axis jerk-limited x/v/a/j profile integrator with one-deep segment shadow and controlled abort.
// Latency: integrator outputs and step/dir/pulses are registered, visible the cycle after the acc_step edge.
// Backpressure: seg_ready drops while the shadow is full, in ABORT, or while abort is asserted.
//
// Ports: clk, reset_n (async active-low); acc_step integration tick; seg (slave modport: seg_valid,
//   seg_ready, seg_len, seg_j); preset/x_val position load (IDLE only); abort level + abort_a
//   per-axis decel magnitude; x/v/a state outputs; step/dir per axis; busy, seg_done, stopped, underrun.
// Optional: define JPG_VMAX_CLAMP_EN to clamp |v| to V_MAX during RUN.
module jerk_profile_gen_mc #(
    parameter int              N_AXES   = 4,
    parameter int              X_W      = 64,
    parameter int              V_W      = 32,
    parameter int              LEN_W    = 24,
    parameter int              STEP_BIT = 32,
    parameter logic [V_W-1:0]  V_MAX    = 32'h3FFF_FFFF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     acc_step,
    jerk_profile_gen_mc_if.slave     seg,
    input  logic                     preset,
    input  logic [N_AXES*X_W-1:0]    x_val,
    input  logic                     abort,
    input  logic [N_AXES*V_W-1:0]    abort_a,
    output logic [N_AXES*X_W-1:0]    x,
    output logic [N_AXES*V_W-1:0]    v,
    output logic [N_AXES*V_W-1:0]    a,
    output logic [N_AXES-1:0]        step,
    output logic [N_AXES-1:0]        dir,
    output logic                     busy,
    output logic                     seg_done,
    output logic                     stopped,
    output logic                     underrun
);

`ifdef JPG_VMAX_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic signed [V_W-1:0] V_LIM = $signed(V_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Integrator state and next values.
    logic signed [X_W-1:0] x_q   [N_AXES];
    logic signed [X_W-1:0] x_d   [N_AXES];
    logic signed [V_W-1:0] v_q   [N_AXES];
    logic signed [V_W-1:0] v_d   [N_AXES];
    logic signed [V_W-1:0] a_q   [N_AXES];
    logic signed [V_W-1:0] a_d   [N_AXES];
    logic signed [V_W-1:0] j_q   [N_AXES];
    logic signed [V_W-1:0] j_d   [N_AXES];

    // Candidate updates for the two motion modes, computed every cycle.
    logic signed [X_W-1:0] run_x [N_AXES];
    logic signed [V_W-1:0] run_v [N_AXES];
    logic signed [V_W-1:0] run_a [N_AXES];
    logic signed [V_W-1:0] abt_v [N_AXES];
    logic signed [V_W-1:0] abt_a [N_AXES];
    logic [N_AXES-1:0]     run_clamp;
    logic                  run_v_zero;
    logic                  abt_v_zero;

    // Active segment counter and shadow entry.
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  sh_full_q, sh_full_d;
    logic [LEN_W-1:0]      sh_len_q, sh_len_d;
    logic signed [V_W-1:0] sh_j_q [N_AXES];
    logic signed [V_W-1:0] sh_j_d [N_AXES];

    logic                  rdy_en_q;
    logic                  abort_hold_q, abort_hold_d;
    logic                  underrun_q, underrun_d;
    logic                  seg_done_q, seg_done_d;
    logic                  stopped_q, stopped_d;
    logic [N_AXES-1:0]     step_q, step_d;
    logic [N_AXES-1:0]     dir_q, dir_d;

    logic                  seg_hs;
    logic                  seg_live;

    // rdy_en_q keeps ready low while reset is asserted and for the release cycle.
    assign seg.seg_ready = rdy_en_q && !sh_full_q && (state_q != S_ABORT) && !abort;
    assign seg_hs        = seg.seg_valid && seg.seg_ready;
    // Zero-length segments complete the handshake but are never stored.
    assign seg_live      = seg_hs && (seg.seg_len != '0);

    // Per-axis candidate updates; all use the old v and a.
    always_comb begin
        run_v_zero = 1'b1;
        abt_v_zero = 1'b1;
        run_clamp  = '0;
        for (int k = 0; k < N_AXES; k++) begin
            run_x[k] = x_q[k] + X_W'(v_q[k]) + X_W'(a_q[k] >>> 1);
            run_v[k] = v_q[k] + a_q[k] + (j_q[k] >>> 1);
            run_a[k] = a_q[k] + j_q[k];
            if (CLAMP_EN) begin
                if (run_v[k] > V_LIM) begin
                    run_v[k]     = V_LIM;
                    run_clamp[k] = 1'b1;
                end else if (run_v[k] < -V_LIM) begin
                    run_v[k]     = -V_LIM;
                    run_clamp[k] = 1'b1;
                end
            end
            // Deceleration toward zero; the last partial step lands exactly on v=0.
            if (v_q[k] > $signed(abort_a[k*V_W +: V_W])) begin
                abt_v[k] = v_q[k] - $signed(abort_a[k*V_W +: V_W]);
                abt_a[k] = -$signed(abort_a[k*V_W +: V_W]);
            end else if (v_q[k] >= -$signed(abort_a[k*V_W +: V_W])) begin
                abt_v[k] = '0;
                abt_a[k] = -v_q[k];
            end else begin
                abt_v[k] = v_q[k] + $signed(abort_a[k*V_W +: V_W]);
                abt_a[k] = $signed(abort_a[k*V_W +: V_W]);
            end
            if (run_v[k] != '0) run_v_zero = 1'b0;
            if (abt_v[k] != '0) abt_v_zero = 1'b0;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_full_d  = sh_full_q;
        sh_len_d   = sh_len_q;
        underrun_d = underrun_q;
        seg_done_d = 1'b0;
        stopped_d  = 1'b0;
        step_d     = '0;
        dir_d      = dir_q;
        for (int k = 0; k < N_AXES; k++) begin
            x_d[k]    = x_q[k];
            v_d[k]    = v_q[k];
            a_d[k]    = a_q[k];
            j_d[k]    = j_q[k];
            sh_j_d[k] = sh_j_q[k];
        end

        unique case (state_q)
            S_IDLE: begin
                if (preset && !acc_step) begin
                    for (int k = 0; k < N_AXES; k++) begin
                        x_d[k] = $signed(x_val[k*X_W +: X_W]);
                        a_d[k] = '0;
                        j_d[k] = '0;
                    end
                    underrun_d = 1'b0;
                end
                // abort_hold_q stops a held abort from re-entering ABORT after it already stopped.
                if (abort && !abort_hold_q) begin
                    state_d   = S_ABORT;
                    sh_full_d = 1'b0;
                    for (int k = 0; k < N_AXES; k++) j_d[k] = '0;
                end else if (seg_live) begin
                    cnt_d   = seg.seg_len;
                    state_d = S_RUN;
                    for (int k = 0; k < N_AXES; k++) j_d[k] = $signed(seg.seg_j[k*V_W +: V_W]);
                end
            end

            S_RUN: begin
                if (acc_step) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    for (int k = 0; k < N_AXES; k++) begin
                        x_d[k] = run_x[k];
                        v_d[k] = run_v[k];
                        a_d[k] = run_clamp[k] ? '0 : run_a[k];
                        if (run_clamp[k]) j_d[k] = '0;
                    end
                end
                if (abort) begin
                    // Abort wins over completion/promotion on the same cycle.
                    state_d   = S_ABORT;
                    sh_full_d = 1'b0;
                    for (int k = 0; k < N_AXES; k++) j_d[k] = '0;
                end else if (acc_step && (cnt_q == LEN_W'(1))) begin
                    seg_done_d = 1'b1;
                    if (sh_full_q) begin
                        cnt_d     = sh_len_q;
                        sh_full_d = 1'b0;
                        for (int k = 0; k < N_AXES; k++) j_d[k] = sh_j_q[k];
                    end else if (run_v_zero) begin
                        state_d = S_IDLE;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = S_ABORT;
                        for (int k = 0; k < N_AXES; k++) j_d[k] = '0;
                    end
                end
                if (seg_live) begin
                    sh_full_d = 1'b1;
                    sh_len_d  = seg.seg_len;
                    for (int k = 0; k < N_AXES; k++) sh_j_d[k] = $signed(seg.seg_j[k*V_W +: V_W]);
                end
            end

            S_ABORT: begin
                sh_full_d = 1'b0;
                for (int k = 0; k < N_AXES; k++) j_d[k] = '0;
                if (acc_step) begin
                    for (int k = 0; k < N_AXES; k++) begin
                        x_d[k] = run_x[k];
                        v_d[k] = abt_v[k];
                        a_d[k] = abt_a[k];
                    end
                    if (abt_v_zero) begin
                        stopped_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Steps come only from motion ticks, never from a preset load.
        for (int k = 0; k < N_AXES; k++) begin
            if ((state_q != S_IDLE) && acc_step && (x_d[k][STEP_BIT] != x_q[k][STEP_BIT])) begin
                step_d[k] = 1'b1;
                dir_d[k]  = (v_q[k] > 0);
            end
        end

        abort_hold_d = abort && (abort_hold_q || stopped_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sh_full_q    <= 1'b0;
            sh_len_q     <= '0;
            rdy_en_q     <= 1'b0;
            abort_hold_q <= 1'b0;
            underrun_q   <= 1'b0;
            seg_done_q   <= 1'b0;
            stopped_q    <= 1'b0;
            step_q       <= '0;
            dir_q        <= '0;
            for (int k = 0; k < N_AXES; k++) begin
                x_q[k]    <= '0;
                v_q[k]    <= '0;
                a_q[k]    <= '0;
                j_q[k]    <= '0;
                sh_j_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_full_q    <= sh_full_d;
            sh_len_q     <= sh_len_d;
            rdy_en_q     <= 1'b1;
            abort_hold_q <= abort_hold_d;
            underrun_q   <= underrun_d;
            seg_done_q   <= seg_done_d;
            stopped_q    <= stopped_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            for (int k = 0; k < N_AXES; k++) begin
                x_q[k]    <= x_d[k];
                v_q[k]    <= v_d[k];
                a_q[k]    <= a_d[k];
                j_q[k]    <= j_d[k];
                sh_j_q[k] <= sh_j_d[k];
            end
        end
    end

    always_comb begin
        x = '0;
        v = '0;
        a = '0;
        for (int k = 0; k < N_AXES; k++) begin
            x[k*X_W +: X_W] = x_q[k];
            v[k*V_W +: V_W] = v_q[k];
            a[k*V_W +: V_W] = a_q[k];
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign busy     = (state_q != S_IDLE);
    assign seg_done = seg_done_q;
    assign stopped  = stopped_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_jerk_profile_gen_mc.sv
// Self-checking bench for jerk_profile_gen_mc: per-tick expectation table fed through a
// scoreboard queue, plus hand-written sequences for shadow backpressure, abort, step, preset
// and asynchronous reset.
module tb_jerk_profile_gen_mc;
    localparam int N  = 4;
    localparam int XW = 64;
    localparam int VW = 32;
    localparam int LW = 24;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              acc_step;
    logic              preset;
    logic              abort;
    logic [N*XW-1:0]   x_val;
    logic [N*VW-1:0]   abort_a;
    logic [N*XW-1:0]   x;
    logic [N*VW-1:0]   v;
    logic [N*VW-1:0]   a;
    logic [N-1:0]      step;
    logic [N-1:0]      dir;
    logic              busy;
    logic              seg_done;
    logic              stopped;
    logic              underrun;

    jerk_profile_gen_mc_if #(.N_AXES(N), .V_W(VW), .LEN_W(LW)) seg_if ();

    jerk_profile_gen_mc dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .acc_step (acc_step),
        .seg      (seg_if),
        .preset   (preset),
        .x_val    (x_val),
        .abort    (abort),
        .abort_a  (abort_a),
        .x        (x),
        .v        (v),
        .a        (a),
        .step     (step),
        .dir      (dir),
        .busy     (busy),
        .seg_done (seg_done),
        .stopped  (stopped),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint v0;
        longint a0;
        longint x0;
        longint v1;
        bit     done;
        bit     stp;
        bit     unr;
        bit     bsy;
    } row_t;

    row_t tbl [17];
    row_t sb [$];
    int   total = 0;
    int   bad   = 0;

    function automatic row_t mk(input longint v0, input longint a0, input longint x0, input longint v1,
                                input bit d, input bit s, input bit u, input bit b);
        row_t r;
        r.v0 = v0; r.a0 = a0; r.x0 = x0; r.v1 = v1;
        r.done = d; r.stp = s; r.unr = u; r.bsy = b;
        return r;
    endfunction

    function automatic longint vx(input int k);
        return longint'($signed(v[k*VW +: VW]));
    endfunction

    function automatic longint ax(input int k);
        return longint'($signed(a[k*VW +: VW]));
    endfunction

    function automatic longint xx(input int k);
        return longint'($signed(x[k*XW +: XW]));
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seg(input int len, input longint j0, input longint j1);
        seg_if.seg_len         = LW'(len);
        seg_if.seg_j           = '0;
        seg_if.seg_j[0 +: VW]  = VW'(j0);
        seg_if.seg_j[VW +: VW] = VW'(j1);
        seg_if.seg_valid       = 1'b1;
    endtask

    task automatic do_preset(input logic [XW-1:0] x0);
        x_val         = '0;
        x_val[0 +: XW] = x0;
        preset        = 1'b1;
        acc_step      = 1'b0;
        tick();
        preset        = 1'b0;
    endtask

    // One acc_step per row; expectations queued at drive time, popped after the edge.
    task automatic run_rows(input int first, input int n);
        row_t e;
        for (int i = first; i < first + n; i++) begin
            acc_step = 1'b1;
            sb.push_back(tbl[i]);
            tick();
            seg_if.seg_valid = 1'b0;
            e = sb.pop_front();
            chk($sformatf("r%0d_v0", i),   vx(0), e.v0);
            chk($sformatf("r%0d_a0", i),   ax(0), e.a0);
            chk($sformatf("r%0d_x0", i),   xx(0), e.x0);
            chk($sformatf("r%0d_v1", i),   vx(1), e.v1);
            chk($sformatf("r%0d_done", i), longint'(seg_done), longint'(e.done));
            chk($sformatf("r%0d_stop", i), longint'(stopped),  longint'(e.stp));
            chk($sformatf("r%0d_unr", i),  longint'(underrun), longint'(e.unr));
            chk($sformatf("r%0d_busy", i), longint'(busy),     longint'(e.bsy));
        end
        acc_step = 1'b0;
    endtask

    task automatic wait_stop(input string nm);
        bit got;
        got = 1'b0;
        acc_step = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            tick();
            if (stopped) got = 1'b1;
        end
        acc_step = 1'b0;
        chk(nm, longint'(got), 1);
    endtask

    // A (len 1, ja), B (len 1, -ja) then C (len 100, j 0): leaves v0 = ja with a0 = 0.
    task automatic load3(input longint ja);
        set_seg(1, ja, 0);
        tick();
        set_seg(1, -ja, 0);
        tick();
        set_seg(100, 0, 0);
        chk("l3_rdy_full", longint'(seg_if.seg_ready), 0);
        acc_step = 1'b1;
        tick();
        chk("l3_done_a", longint'(seg_done), 1);
        chk("l3_v_a", vx(0), ja / 2);
        acc_step = 1'b0;
        chk("l3_rdy_after_promo", longint'(seg_if.seg_ready), 1);
        tick();
        seg_if.seg_valid = 1'b0;
        acc_step = 1'b1;
        tick();
        chk("l3_done_b", longint'(seg_done), 1);
        chk("l3_v_b", vx(0), ja);
        chk("l3_a_b", ax(0), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        // Scenario 1: single-segment j=+2 (axis 1 j=-2), then underrun abort with d=4.
        tbl[0]  = mk(1,   2,  0,  -1, 0, 0, 0, 1);
        tbl[1]  = mk(4,   4,  2,  -4, 0, 0, 0, 1);
        tbl[2]  = mk(9,   6,  8,  -9, 0, 0, 0, 1);
        tbl[3]  = mk(16,  8, 20, -16, 1, 0, 1, 1);
        tbl[4]  = mk(12, -4, 40, -12, 0, 0, 1, 1);
        tbl[5]  = mk(8,  -4, 50,  -8, 0, 0, 1, 1);
        tbl[6]  = mk(4,  -4, 56,  -4, 0, 0, 1, 1);
        tbl[7]  = mk(0,  -4, 58,   0, 0, 1, 1, 0);
        // Scenario 2: back-to-back len 3 j=+4 then len 3 j=-4.
        tbl[8]  = mk(2,   4,   0, 0, 0, 0, 0, 1);
        tbl[9]  = mk(8,   8,   4, 0, 0, 0, 0, 1);
        tbl[10] = mk(18, 12,  16, 0, 1, 0, 0, 1);
        tbl[11] = mk(28,  8,  40, 0, 0, 0, 0, 1);
        tbl[12] = mk(34,  4,  72, 0, 0, 0, 0, 1);
        tbl[13] = mk(36,  0, 108, 0, 1, 0, 1, 1);
        // Abort from v=10, d=4.
        tbl[14] = mk(6,  -4, 40, 0, 0, 0, 0, 1);
        tbl[15] = mk(2,  -4, 44, 0, 0, 0, 0, 1);
        tbl[16] = mk(0,  -2, 44, 0, 0, 1, 0, 0);

        reset_n  = 1'b0;
        acc_step = 1'b0;
        preset   = 1'b0;
        abort    = 1'b0;
        x_val    = '0;
        abort_a  = '0;
        for (int k = 0; k < N; k++) abort_a[k*VW +: VW] = VW'(4);
        seg_if.seg_valid = 1'b0;
        seg_if.seg_len   = '0;
        seg_if.seg_j     = '0;

        tick();
        tick();
        chk("rst_rdy",   longint'(seg_if.seg_ready), 0);
        chk("rst_x0",    xx(0), 0);
        chk("rst_v0",    vx(0), 0);
        chk("rst_a0",    ax(0), 0);
        chk("rst_busy",  longint'(busy), 0);
        chk("rst_step",  longint'(step), 0);
        chk("rst_dir",   longint'(dir), 0);
        chk("rst_done",  longint'(seg_done), 0);
        chk("rst_stop",  longint'(stopped), 0);
        chk("rst_unr",   longint'(underrun), 0);
        reset_n = 1'b1;
        tick();
        chk("rst_rdy_after", longint'(seg_if.seg_ready), 1);

        // Scenario 1
        set_seg(4, 2, -2);
        tick();
        seg_if.seg_valid = 1'b0;
        chk("s1_busy_load", longint'(busy), 1);
        run_rows(0, 8);

        // Scenario 2
        do_preset('0);
        chk("s2_unr_clear", longint'(underrun), 0);
        chk("s2_a1_clear",  ax(1), 0);
        chk("s2_x0_preset", xx(0), 0);
        set_seg(3, 4, 0);
        tick();
        set_seg(3, -4, 0);
        run_rows(8, 6);
        wait_stop("s2_stopped");
        chk("s2_idle", longint'(busy), 0);
        chk("s2_v0",   vx(0), 0);

        // Zero-length segment: accepted and dropped.
        do_preset('0);
        set_seg(0, 5, 5);
        chk("z_rdy", longint'(seg_if.seg_ready), 1);
        tick();
        seg_if.seg_valid = 1'b0;
        chk("z_busy", longint'(busy), 0);
        chk("z_done", longint'(seg_done), 0);
        tick();
        chk("z_busy2", longint'(busy), 0);

        // Abort from a constant v=10.
        do_preset('0);
        load3(10);
        tick();
        tick();
        chk("ab_v_hold", vx(0), 10);
        chk("ab_x",      xx(0), 30);
        acc_step = 1'b0;
        abort    = 1'b1;
        #1;
        chk("ab_rdy_low", longint'(seg_if.seg_ready), 0);
        tick();
        chk("ab_busy", longint'(busy), 1);
        run_rows(14, 3);
        acc_step = 1'b1;
        tick();
        tick();
        acc_step = 1'b0;
        chk("ab_hold_stop", longint'(stopped), 0);
        chk("ab_hold_idle", longint'(busy), 0);
        chk("ab_hold_rdy",  longint'(seg_if.seg_ready), 0);
        abort = 1'b0;
        #1;
        chk("ab_release_rdy", longint'(seg_if.seg_ready), 1);

        // Step on bit 32 crossing.
        tick();
        do_preset(64'h0000_0000_FFFF_FFF0);
        chk("st_preset_x", xx(0), 64'h0000_0000_FFFF_FFF0);
        chk("st_preset_step", longint'(step), 0);
        load3(8);
        chk("st_x_pre", xx(0), 64'h0000_0000_FFFF_FFF8);
        chk("st_step_pre", longint'(step[0]), 0);
        tick();
        chk("st_x_cross", xx(0), 64'h0000_0001_0000_0000);
        chk("st_step", longint'(step[0]), 1);
        chk("st_dir",  longint'(dir[0]), 1);
        tick();
        chk("st_step_after", longint'(step[0]), 0);
        chk("st_dir_hold",   longint'(dir[0]), 1);

        // Asynchronous reset while running.
        acc_step = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("ar_x0",   xx(0), 0);
        chk("ar_v0",   vx(0), 0);
        chk("ar_busy", longint'(busy), 0);
        chk("ar_rdy",  longint'(seg_if.seg_ready), 0);
        chk("ar_dir",  longint'(dir), 0);
        chk("ar_unr",  longint'(underrun), 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("ar_rdy_rel", longint'(seg_if.seg_ready), 0);
        tick();
        chk("ar_rdy_next", longint'(seg_if.seg_ready), 1);
        chk("ar_done", longint'(seg_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
